// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side streaming stage.
package fifo_rd_stream_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int BUF_DEPTH_DEF = 3;
  localparam int CNT_WIDTH_DEF = 16;

  function automatic int clog2_occ(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Circular prefetch buffer: one write strobe, one pop strobe, occupancy count.
module rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int  WIDTH = FIFO_WIDTH,
  parameter int  DEPTH = BUF_DEPTH_DEF,
  localparam int OCC_W = clog2_occ(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Explicit wrap so non-power-of-two depths never touch unused slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
    if (wr_en) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign occ     = occ_q;
  assign valid   = (occ_q != '0);
  assign rd_data = valid ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read sync FIFO into a valid/ready stream via a credit-
// limited prefetch buffer; reads never depend combinationally on m_ready.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int  FIFO_WIDTH = fifo_rd_stream_pkg::FIFO_WIDTH,
  parameter int  BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int  CNT_WIDTH  = CNT_WIDTH_DEF,
  localparam int OCC_W      = clog2_occ(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [OCC_W-1:0]      occ
);

  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [OCC_W:0]        credit_used;
  logic                  buf_valid;
  logic [FIFO_WIDTH-1:0] buf_data;
  logic                  fire;

  // Credit counts both stored words and the one still in the FIFO's read stage.
  always_comb begin
    credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    fifo_rd_en  = !rst && !fifo_empty && (credit_used < (OCC_W + 1)'(BUF_DEPTH));
    m_valid     = !rst && buf_valid;
    m_data      = m_valid ? buf_data : '0;
    fire        = m_valid && m_ready;
    inflight_d  = fifo_rd_en;
    xfer_cnt_d  = xfer_cnt_q + {{(CNT_WIDTH - 1){1'b0}}, fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  rd_stream_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (fifo_dout),
    .pop     (fire),
    .occ     (occ),
    .valid   (buf_valid),
    .rd_data (buf_data)
  );

  assign xfer_cnt = xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit_used <= (OCC_W + 1)'(BUF_DEPTH));
      assert (!(fifo_rd_en && fifo_empty));
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and scoreboarded checks of fifo_rd_stream against a behavioural FIFO.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        empty [3];
  logic [15:0] dout  [3];
  logic        rd_en [3];
  logic        mv    [3];
  logic [15:0] md    [3];
  logic        mr    [3];
  logic [1:0]  occ   [3];
  logic [15:0] xfer0, xfer2;
  logic [3:0]  xfer1;

  fifo_rd_stream #(.FIFO_WIDTH(16), .BUF_DEPTH(3), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_dout(dout[0]), .fifo_rd_en(rd_en[0]),
    .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]), .xfer_cnt(xfer0), .occ(occ[0]));
  fifo_rd_stream #(.FIFO_WIDTH(16), .BUF_DEPTH(3), .CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_dout(dout[1]), .fifo_rd_en(rd_en[1]),
    .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]), .xfer_cnt(xfer1), .occ(occ[1]));
  fifo_rd_stream #(.FIFO_WIDTH(16), .BUF_DEPTH(2), .CNT_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(empty[2]), .fifo_dout(dout[2]), .fifo_rd_en(rd_en[2]),
    .m_valid(mv[2]), .m_data(md[2]), .m_ready(mr[2]), .xfer_cnt(xfer2), .occ(occ[2]));

  typedef struct {
    bit          push;
    logic [15:0] pdata;
    bit          rdy;
    bit          e_valid;
    logic [15:0] e_data;
    int          e_occ;
    bit          e_rd;
    int          e_xfer;
  } vec_t;

  vec_t        tbl [12];
  logic [15:0] fq [3][$];
  logic [15:0] eq [3][$];
  logic [15:0] nd [3];
  logic        rd_s [3];
  logic        rst_s;
  int          pops [3];
  int          tests, fails;
  int          first_rd, first_v, last_v, nv, nrd, nf;
  bit          done;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push(int d, logic [15:0] v);
    fq[d].push_back(v);
    empty[d] = 1'b0;
  endtask

  // Negedge: sample outputs, score every accepted word, record read requests.
  task automatic sample();
    @(negedge clk);
    rst_s = rst;
    for (int d = 0; d < 3; d++) begin
      rd_s[d] = rd_en[d];
      if (rd_en[d]) chk($sformatf("rd_while_empty_d%0d", d), int'(empty[d]), 0);
      if (!rst && mv[d] && mr[d]) begin
        if (eq[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word_d%0d: got 0x%0h, want no word", d, md[d]);
        end else begin
          chk($sformatf("order_d%0d", d), int'(md[d]), int'(eq[d].pop_front()));
        end
        pops[d]++;
      end
    end
  endtask

  // Posedge: behavioural FIFO with one-cycle registered read.
  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst_s) begin
        eq[d].delete();
        pops[d] = 0;
      end else if (rd_s[d] && fq[d].size() > 0) begin
        nd[d] = fq[d].pop_front();
        eq[d].push_back(nd[d]);
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      dout[d]  = nd[d];
      empty[d] = (fq[d].size() == 0);
    end
  endtask

  task automatic drain(int d, int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      sample();
      ok = (fq[d].size() == 0) && (eq[d].size() == 0) && !mv[d];
      advance();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    rst_s = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mr[d] = 1'b0; empty[d] = 1'b1; dout[d] = '0; nd[d] = '0; pops[d] = 0; rd_s[d] = 1'b0;
    end

    //            push pdata    rdy val data     occ rd xfer
    tbl[0]  = '{1, 16'h00A1, 0, 0, 16'h0000, 0, 1, 0};
    tbl[1]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
    tbl[2]  = '{1, 16'h00A2, 0, 1, 16'h00A1, 1, 1, 0};
    tbl[3]  = '{1, 16'h00A3, 0, 1, 16'h00A1, 1, 1, 0};
    tbl[4]  = '{1, 16'h00A4, 0, 1, 16'h00A1, 2, 0, 0};
    tbl[5]  = '{0, 16'h0000, 0, 1, 16'h00A1, 3, 0, 0};
    tbl[6]  = '{0, 16'h0000, 1, 1, 16'h00A1, 3, 0, 0};
    tbl[7]  = '{0, 16'h0000, 1, 1, 16'h00A2, 2, 1, 1};
    tbl[8]  = '{0, 16'h0000, 1, 1, 16'h00A3, 1, 0, 2};
    tbl[9]  = '{0, 16'h0000, 1, 1, 16'h00A4, 1, 0, 3};
    tbl[10] = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 4};
    tbl[11] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4};

    // Reset
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid_d%0d", d), int'(mv[d]), 0);
      chk($sformatf("rst_data_d%0d", d), int'(md[d]), 0);
      chk($sformatf("rst_rd_en_d%0d", d), int'(rd_en[d]), 0);
    end
    advance();
    sample();
    advance();
    rst = 1'b0;
    sample();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_valid_d%0d", d), int'(mv[d]), 0);
      chk($sformatf("post_rst_occ_d%0d", d), int'(occ[d]), 0);
    end
    chk("post_rst_xfer_d0", int'(xfer0), 0);
    chk("post_rst_xfer_d1", int'(xfer1), 0);
    chk("post_rst_xfer_d2", int'(xfer2), 0);
    advance();

    // Table: fill to full under backpressure, then release
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push) push(0, tbl[i].pdata);
      mr[0] = tbl[i].rdy;
      sample();
      chk($sformatf("tbl%0d_valid", i), int'(mv[0]), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), int'(md[0]), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_occ", i), int'(occ[0]), tbl[i].e_occ);
      chk($sformatf("tbl%0d_rd_en", i), int'(rd_en[0]), int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_xfer", i), int'(xfer0), tbl[i].e_xfer);
      advance();
    end

    // Streaming: 10 words, one per cycle
    for (int i = 0; i < 10; i++) push(0, 16'(i));
    mr[0] = 1'b1;
    first_rd = -1; first_v = -1; last_v = -1; nv = 0;
    for (int c = 0; c < 16; c++) begin
      sample();
      if (rd_s[0] && first_rd < 0) first_rd = c;
      if (mv[0]) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
      advance();
    end
    chk("stream_first_rd", first_rd, 0);
    chk("stream_latency", first_v - first_rd, 2);
    chk("stream_count", nv, 10);
    chk("stream_back_to_back", last_v - first_v, 9);
    sample();
    chk("stream_xfer", int'(xfer0), 14);
    advance();

    // Backpressure: 20 words, sink stalled
    mr[0] = 1'b0;
    for (int i = 0; i < 20; i++) push(0, 16'(i));
    nrd = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (rd_s[0]) nrd++;
      if (mv[0]) chk("bp_hold_data", int'(md[0]), 0);
      advance();
    end
    sample();
    chk("bp_reads", nrd, 3);
    chk("bp_occ", int'(occ[0]), 3);
    chk("bp_valid", int'(mv[0]), 1);
    chk("bp_rd_en", int'(rd_en[0]), 0);
    advance();
    mr[0] = 1'b1;
    drain(0, 60, done);
    chk("bp_drained", int'(done), 1);
    chk("bp_xfer", int'(xfer0), 34);

    // Reset flush with a full buffer
    mr[0] = 1'b0;
    push(0, 16'h0011); push(0, 16'h0022); push(0, 16'h0033);
    for (int c = 0; c < 6; c++) begin
      sample();
      advance();
    end
    sample();
    chk("flush_loaded_occ", int'(occ[0]), 3);
    advance();
    rst = 1'b1;
    sample();
    chk("flush_valid_in_rst", int'(mv[0]), 0);
    chk("flush_data_in_rst", int'(md[0]), 0);
    advance();
    rst = 1'b0;
    sample();
    chk("flush_valid", int'(mv[0]), 0);
    chk("flush_occ", int'(occ[0]), 0);
    chk("flush_xfer", int'(xfer0), 0);
    advance();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("flush_stays_empty", int'(mv[0]), 0);
      advance();
    end

    // Reset while a read is in flight: that word must be dropped
    push(0, 16'h0055); push(0, 16'h0066); push(0, 16'h0077);
    sample(); advance();
    sample(); advance();
    rst = 1'b1;
    sample();
    chk("inflight_rst_rd_en", int'(rd_en[0]), 0);
    advance();
    rst = 1'b0;
    sample();
    chk("inflight_first_read", int'(rd_en[0]), 1);
    chk("inflight_valid_c3", int'(mv[0]), 0);
    advance();
    sample();
    chk("inflight_valid_c4", int'(mv[0]), 0);
    advance();
    sample();
    chk("inflight_valid_c5", int'(mv[0]), 1);
    chk("inflight_data_c5", int'(md[0]), 16'h0077);
    chk("inflight_occ_c5", int'(occ[0]), 1);
    advance();
    mr[0] = 1'b1;
    sample(); advance();
    mr[0] = 1'b0;
    sample();
    chk("inflight_after_valid", int'(mv[0]), 0);
    chk("inflight_after_xfer", int'(xfer0), 1);
    advance();

    // Random writes and stalls
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(1) == 1) push(0, 16'($urandom));
      mr[0] = ($urandom_range(1) == 1);
      sample();
      advance();
    end
    mr[0] = 1'b1;
    drain(0, 4000, done);
    chk("rand_drained", int'(done), 1);
    chk("rand_xfer_vs_pops", int'(xfer0), pops[0] & 32'hFFFF);

    // Counter wrap at CNT_WIDTH=4
    for (int i = 0; i < 17; i++) push(1, 16'h0200 + 16'(i));
    mr[1] = 1'b1;
    drain(1, 80, done);
    chk("wrap_drained", int'(done), 1);
    chk("wrap_xfer", int'(xfer1), 1);

    // BUF_DEPTH=2: two words every three cycles
    for (int i = 0; i < 12; i++) push(2, 16'h0300 + 16'(i));
    mr[2] = 1'b1;
    first_rd = -1; last_v = -1; nf = 0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (rd_s[2] && first_rd < 0) first_rd = c;
      if (mv[2]) begin
        nf++;
        last_v = c;
      end
      advance();
    end
    chk("d2_count", nf, 12);
    chk("d2_span", last_v - first_rd, 18);
    chk("d2_xfer", int'(xfer2), 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
